// File: rtl/fake_n64_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fake_n64_pkg
//  Description : Shared Joybus timing constants, receiver state encoding and
//                controller command codes (used by the receiver and the
//                transmitter).
//  Revision    : 1.0 - initial release
// ============================================================================
package fake_n64_pkg;

  // Wire timing: one bit cell is four levels of LEVEL_WIDTH sample cycles.
  localparam int LEVEL_WIDTH = 2;
  localparam int BIT_WIDTH   = 4 * LEVEL_WIDTH;

  // Counter widths derived from the bit cell.
  localparam int CYC_W = $clog2(BIT_WIDTH);
  localparam int LO_W  = $clog2(BIT_WIDTH + 2);

  // Receiver state encoding.
  localparam int STATE_SIZE = 3;
  typedef enum logic [STATE_SIZE-1:0] {
    ST_IDLE,
    ST_IN_BIT,
    ST_GAP,
    ST_HANDOFF,
    ST_RECOVER
  } rx_state_t;

  // Console command bytes.
  localparam logic [7:0] CMD_INFO   = 8'h00;
  localparam logic [7:0] CMD_STATUS = 8'h01;
  localparam logic [7:0] CMD_READ   = 8'h02;
  localparam logic [7:0] CMD_WRITE  = 8'h03;
  localparam logic [7:0] CMD_RESET  = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/fake_n64_controller_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : fake_n64_controller_rx_if
//  Description : Line, handoff and decoded-command signals of the Joybus
//                receiver. master = receiver, slave = its consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fake_n64_controller_rx_if;
  logic       data_rx;
  logic       rx_handoff;
  logic [7:0] cmd;
  logic       cmd_valid;
  logic       cur_operation;
  logic [5:0] bit_count;
  logic       rx_error;

  modport master (
    input  data_rx, rx_handoff,
    output cmd, cmd_valid, cur_operation, bit_count, rx_error
  );

  modport slave (
    output data_rx, rx_handoff,
    input  cmd, cmd_valid, cur_operation, bit_count, rx_error
  );
endinterface
`default_nettype wire

// File: rtl/fake_n64_controller_rx_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : joybus_bit_sampler
//  Description : Registers the Joybus line, detects falling edges, tracks the
//                position inside the bit cell, samples mid-cell and flags a
//                line held low for longer than one bit cell.
//                Optional FAKE_N64_RX_SYNC_EN adds a 2-flop synchronizer.
//  Revision    : 1.0 - initial release
// ============================================================================
module joybus_bit_sampler
  import fake_n64_pkg::*;
(
  input  logic sample_clk,
  input  logic reset_n,
  input  logic data_rx,
  input  logic prev_force,   // make the next cycle's history read high
  output logic line,
  output logic fall_edge,
  output logic bit_strobe,
  output logic bit_value,
  output logic bit_end,
  output logic low_overrun
);

  localparam logic [CYC_W-1:0] CYC_MID  = CYC_W'(2 * LEVEL_WIDTH);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_WIDTH - 1);
  localparam logic [LO_W-1:0]  LO_LIMIT = LO_W'(BIT_WIDTH + 1);

  logic             w_line_in;
  logic             r_line;
  logic             r_prev;
  logic [CYC_W-1:0] r_cyc;
  logic [CYC_W-1:0] w_cyc_next;
  logic [LO_W-1:0]  r_lo_run;
  logic [LO_W-1:0]  w_lo_run;

`ifdef FAKE_N64_RX_SYNC_EN
  logic [1:0] r_sync;
  // Two-flop synchronizer, idling high like the bus
  always_ff @(posedge sample_clk) begin
    if (!reset_n) r_sync <= 2'b11;
    else          r_sync <= {r_sync[0], data_rx};
  end
  assign w_line_in = r_sync[1];
`else
  assign w_line_in = data_rx;
`endif

  // Line/history registers and cell-position/low-run counters
  always_ff @(posedge sample_clk) begin
    if (!reset_n) begin
      r_line   <= 1'b1;
      r_prev   <= 1'b1;
      r_cyc    <= CYC_LAST;
      r_lo_run <= '0;
    end else begin
      r_line   <= w_line_in;
      r_prev   <= prev_force | r_line;
      r_cyc    <= w_cyc_next;
      r_lo_run <= w_lo_run;
    end
  end

  assign fall_edge = r_prev & ~r_line;

  // Cell position: the falling-edge cycle is position 0, saturating at the cell end
  always_comb begin
    if (fall_edge)             w_cyc_next = CYC_W'(1);
    else if (r_cyc == CYC_LAST) w_cyc_next = r_cyc;
    else                       w_cyc_next = r_cyc + 1'b1;
  end

  // Consecutive low samples including the current one, restarted by a falling edge
  always_comb begin
    if (r_line)                    w_lo_run = '0;
    else if (fall_edge)            w_lo_run = LO_W'(1);
    else if (r_lo_run == LO_LIMIT) w_lo_run = r_lo_run;
    else                           w_lo_run = r_lo_run + 1'b1;
  end

  assign line        = r_line;
  assign bit_strobe  = (r_cyc == CYC_MID);
  assign bit_value   = r_line;
  assign bit_end     = (r_cyc == CYC_LAST);
  assign low_overrun = (w_lo_run == LO_LIMIT);

endmodule
`default_nettype wire

// File: rtl/fake_n64_controller_rx.sv
`default_nettype none
// ============================================================================
//  Module      : fake_n64_controller_rx
//  Description : Joybus receive front end of the fake N64 controller. Decodes
//                L/H bit cells, ends frames on an idle timeout, latches the
//                command byte and hands the line to the transmitter.
//                Optional FAKE_N64_RX_SYNC_EN (in joybus_bit_sampler) adds a
//                2-flop input synchronizer (+2 cycles latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module fake_n64_controller_rx
  import fake_n64_pkg::*;
#(
  parameter int IDLE_CYCLES = 12,   // must exceed 3*LEVEL_WIDTH
  parameter int MAX_BITS    = 63
)(
  input  logic sample_clk,
  input  logic reset_n,
  fake_n64_controller_rx_if.master bus
);

  localparam int              HI_W     = $clog2(IDLE_CYCLES + 1);
  localparam logic [HI_W-1:0] HI_LIMIT = HI_W'(IDLE_CYCLES);
  localparam logic [5:0]      BITS_MAX = 6'(MAX_BITS);

  rx_state_t       r_state, w_state_next;
  logic [5:0]      r_bits, w_bits_next;
  logic [7:0]      r_shreg, w_shreg_next;
  logic            r_last_bit, w_last_bit_next;
  logic [HI_W-1:0] r_hi_run, w_hi_run;
  logic [7:0]      r_cmd, w_cmd_next;
  logic            r_cmd_valid, w_cmd_valid_next;
  logic            r_cur_op, w_cur_op_next;
  logic [5:0]      r_bit_count, w_bit_count_next;
  logic            r_rx_error, w_rx_error_next;
  logic            w_prev_force, w_hi_done;
  logic            w_line, w_fall, w_bit_strobe, w_bit_value, w_bit_end, w_low_overrun;

  joybus_bit_sampler u_sampler (
    .sample_clk  (sample_clk),
    .reset_n     (reset_n),
    .data_rx     (bus.data_rx),
    .prev_force  (w_prev_force),
    .line        (w_line),
    .fall_edge   (w_fall),
    .bit_strobe  (w_bit_strobe),
    .bit_value   (w_bit_value),
    .bit_end     (w_bit_end),
    .low_overrun (w_low_overrun)
  );

  // Consecutive high samples including the current one; drives idle timeout
  always_comb begin
    if (!w_line)                   w_hi_run = '0;
    else if (r_hi_run == HI_LIMIT) w_hi_run = r_hi_run;
    else                           w_hi_run = r_hi_run + 1'b1;
  end
  assign w_hi_done = (w_hi_run == HI_LIMIT);

  // State and output registers
  always_ff @(posedge sample_clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_bits      <= '0;
      r_shreg     <= '0;
      r_last_bit  <= 1'b0;
      r_hi_run    <= '0;
      r_cmd       <= '0;
      r_cmd_valid <= 1'b0;
      r_cur_op    <= 1'b0;
      r_bit_count <= '0;
      r_rx_error  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_bits      <= w_bits_next;
      r_shreg     <= w_shreg_next;
      r_last_bit  <= w_last_bit_next;
      r_hi_run    <= w_hi_run;
      r_cmd       <= w_cmd_next;
      r_cmd_valid <= w_cmd_valid_next;
      r_cur_op    <= w_cur_op_next;
      r_bit_count <= w_bit_count_next;
      r_rx_error  <= w_rx_error_next;
    end
  end

  // Frame decode: next state, bit accumulation and frame-end outputs
  always_comb begin
    w_state_next     = r_state;
    w_bits_next      = r_bits;
    w_shreg_next     = r_shreg;
    w_last_bit_next  = r_last_bit;
    w_cmd_next       = r_cmd;
    w_cmd_valid_next = 1'b0;
    w_cur_op_next    = r_cur_op;
    w_bit_count_next = r_bit_count;
    w_rx_error_next  = 1'b0;
    w_prev_force     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_state_next = ST_IN_BIT;
          w_bits_next  = '0;
          w_shreg_next = '0;
        end
      end
      ST_IN_BIT: begin
        if (w_low_overrun) begin
          w_rx_error_next = 1'b1;
          w_state_next    = ST_RECOVER;
        end else begin
          if (w_bit_strobe) begin
            // Only the first byte is kept; payload bits are just counted.
            if (r_bits < 6'd8) w_shreg_next = {r_shreg[6:0], w_bit_value};
            if (r_bits != BITS_MAX) w_bits_next = r_bits + 1'b1;
            w_last_bit_next = w_bit_value;
          end
          if (w_bit_end) w_state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (w_low_overrun) begin
          w_rx_error_next = 1'b1;
          w_state_next    = ST_RECOVER;
        end else if (w_fall) begin
          w_state_next = ST_IN_BIT;
        end else if (w_hi_done) begin
          if (r_bits >= 6'd9 && r_last_bit) begin
            w_cmd_next       = r_shreg;
            w_bit_count_next = r_bits;
            w_cmd_valid_next = 1'b1;
            w_cur_op_next    = 1'b1;
            w_state_next     = ST_HANDOFF;
          end else begin
            w_rx_error_next = 1'b1;
            w_state_next    = ST_IDLE;
          end
        end
      end
      ST_HANDOFF: begin
        // The transmitter owns the line; only its completion is watched.
        if (bus.rx_handoff) begin
          w_cur_op_next = 1'b0;
          w_prev_force  = 1'b1;
          w_state_next  = ST_IDLE;
        end
      end
      ST_RECOVER: begin
        if (w_hi_done) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign bus.cmd           = r_cmd;
  assign bus.cmd_valid     = r_cmd_valid;
  assign bus.cur_operation = r_cur_op;
  assign bus.bit_count     = r_bit_count;
  assign bus.rx_error      = r_rx_error;

endmodule
`default_nettype wire

// File: tb/tb_fake_n64_controller_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fake_n64_controller_rx
//  Description : Directed self-checking bench for fake_n64_controller_rx
//                (LEVEL_WIDTH = 2, IDLE_CYCLES = 12).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fake_n64_controller_rx;

  localparam int LW = 2;

  logic sample_clk = 1'b0;
  logic reset_n    = 1'b0;
  int   n_cmp = 0, n_fail = 0;
  int   n_valid = 0, n_err = 0;
  int   tb_cyc = 0, valid_cyc = 0, rise_cyc = 0;
  int   v0 = 0, e0 = 0;

  fake_n64_controller_rx_if bus ();

  fake_n64_controller_rx dut (
    .sample_clk (sample_clk),
    .reset_n    (reset_n),
    .bus        (bus)
  );

  always #5 sample_clk = ~sample_clk;

  // Cycle index of the most recent rising edge
  always @(posedge sample_clk) tb_cyc <= tb_cyc + 1;

  // Pulse counters sampled mid-cycle
  always @(negedge sample_clk) begin
    if (bus.cmd_valid === 1'b1) begin
      n_valid   = n_valid + 1;
      valid_cyc = tb_cyc;
    end
    if (bus.rx_error === 1'b1) n_err = n_err + 1;
  end

  task automatic tick();
    @(posedge sample_clk);
    #1;
  endtask

  task automatic drive(input logic v, input int n);
    bus.data_rx = v;
    repeat (n) tick();
  endtask

  // L/H cell: 0 = 3 levels low + 1 high, 1 = 1 level low + 3 high
  task automatic send_bit(input logic b);
    drive(1'b0, b ? LW : 3 * LW);
    drive(1'b1, b ? 3 * LW : LW);
  endtask

  task automatic send_byte(input logic [7:0] x);
    for (int i = 7; i >= 0; i--) send_bit(x[i]);
  endtask

  // Stop bit, remembering the cycle after which the line returns high
  task automatic send_stop();
    drive(1'b0, LW);
    rise_cyc = tb_cyc;
    drive(1'b1, 24);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic handoff();
    bus.rx_handoff = 1'b1;
    tick();
    bus.rx_handoff = 1'b0;
    drive(1'b1, 4);
  endtask

  initial begin
    bus.data_rx    = 1'b0;
    bus.rx_handoff = 1'b0;

    // Reset held two cycles while the line toggles
    tick();
    bus.data_rx = 1'b1;
    tick();
    check("reset_cmd",       32'(bus.cmd), 32'h00);
    check("reset_cmd_valid", 32'(bus.cmd_valid), 32'h0);
    check("reset_cur_op",    32'(bus.cur_operation), 32'h0);
    check("reset_bit_count", 32'(bus.bit_count), 32'h0);
    check("reset_rx_error",  32'(bus.rx_error), 32'h0);
    reset_n = 1'b1;
    drive(1'b1, 6);

    // STATUS 0x01 + stop
    v0 = n_valid; e0 = n_err;
    send_byte(8'h01);
    send_stop();
    check("status_valid_cnt", 32'(n_valid - v0), 32'd1);
    check("status_latency",   32'(valid_cyc - rise_cyc), 32'd13);
    check("status_cmd",       32'(bus.cmd), 32'h01);
    check("status_bit_count", 32'(bus.bit_count), 32'd9);
    check("status_cur_op",    32'(bus.cur_operation), 32'h1);
    check("status_no_error",  32'(n_err - e0), 32'd0);
    bus.rx_handoff = 1'b1;
    tick();
    check("handoff_release",  32'(bus.cur_operation), 32'h0);
    bus.rx_handoff = 1'b0;
    drive(1'b1, 4);

    // RESET 0xFF + stop
    v0 = n_valid;
    send_byte(8'hFF);
    send_stop();
    check("reset_cmd_frame",  32'(bus.cmd), 32'hFF);
    check("reset_frame_bits", 32'(bus.bit_count), 32'd9);
    check("reset_frame_cnt",  32'(n_valid - v0), 32'd1);
    handoff();

    // READ 0x02 + 16 address bits + stop
    v0 = n_valid; e0 = n_err;
    send_byte(8'h02);
    send_byte(8'hA5);
    send_byte(8'h5A);
    send_stop();
    check("read_cmd",       32'(bus.cmd), 32'h02);
    check("read_bit_count", 32'(bus.bit_count), 32'd25);
    check("read_valid_cnt", 32'(n_valid - v0), 32'd1);
    check("read_no_error",  32'(n_err - e0), 32'd0);

    // Line activity while the transmitter owns it
    v0 = n_valid; e0 = n_err;
    for (int i = 0; i < 40; i++) begin
      bus.data_rx = ~bus.data_rx;
      tick();
    end
    drive(1'b1, 3);
    check("iso_no_valid",  32'(n_valid - v0), 32'd0);
    check("iso_no_error",  32'(n_err - e0), 32'd0);
    check("iso_cmd",       32'(bus.cmd), 32'h02);
    check("iso_bit_count", 32'(bus.bit_count), 32'd25);
    check("iso_cur_op",    32'(bus.cur_operation), 32'h1);
    handoff();
    check("iso_released",  32'(bus.cur_operation), 32'h0);

    // Line held low for 20 cycles, then exactly 12 high before a new frame
    v0 = n_valid; e0 = n_err;
    drive(1'b0, 20);
    check("overrun_err_cnt",  32'(n_err - e0), 32'd1);
    check("overrun_no_valid", 32'(n_valid - v0), 32'd0);
    drive(1'b1, 12);
    send_byte(8'h01);
    send_stop();
    check("recover_valid_cnt", 32'(n_valid - v0), 32'd1);
    check("recover_cmd",       32'(bus.cmd), 32'h01);
    check("recover_err_cnt",   32'(n_err - e0), 32'd1);
    handoff();

    // 8-bit frame ending in 0 (no stop bit)
    v0 = n_valid; e0 = n_err;
    send_byte(8'h00);
    drive(1'b1, 24);
    check("short_err_cnt",  32'(n_err - e0), 32'd1);
    check("short_no_valid", 32'(n_valid - v0), 32'd0);
    check("short_cmd_kept", 32'(bus.cmd), 32'h01);
    check("short_bits_kept", 32'(bus.bit_count), 32'd9);
    check("short_cur_op",   32'(bus.cur_operation), 32'h0);

    // Reset after 4 bits of 0x01, then a clean INFO 0x00 frame
    v0 = n_valid; e0 = n_err;
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    reset_n     = 1'b0;
    bus.data_rx = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    check("midrst_cmd_cleared",  32'(bus.cmd), 32'h00);
    check("midrst_bits_cleared", 32'(bus.bit_count), 32'd0);
    drive(1'b1, 4);
    send_byte(8'h00);
    send_stop();
    check("midrst_valid_cnt", 32'(n_valid - v0), 32'd1);
    check("midrst_cmd",       32'(bus.cmd), 32'h00);
    check("midrst_bit_count", 32'(bus.bit_count), 32'd9);
    check("midrst_no_error",  32'(n_err - e0), 32'd0);
    handoff();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
